// File: rtl/pnu_debounce_pulse.sv
// -----------------------------------------------------------------------------
// pnu_debounce_pulse
//   Turns a raw mechanical push-button into a clean one-cycle clock-enable
//   strobe for the downstream Ce pin. The button passes through a 2-FF
//   synchronizer and then a debounce FSM with a stability counter. A one-shot
//   stage emits the strobe, and the emitted strobes are counted.
//
// Optional feature macro: PNU_DEBOUNCE_REPEAT_EN
//   When it is defined, holding the button in HELD auto-repeats the strobe:
//   the first repeat comes REPEAT_DELAY cycles after the press strobe, and
//   later repeats come every REPEAT_PERIOD cycles.
//   When it is undefined, each accepted press gives exactly one strobe and
//   the REPEAT_* parameters are ignored.
//
// Ports
//   clock      in   1  rising-edge clock
//   reset      in   1  synchronous, active-high reset
//   btn_in     in   1  raw asynchronous button level, 1 = pressed
//   en         in   1  1 = allow ce_out strobes (FSM runs regardless)
//   ce_out     out  1  one-cycle strobe per accepted press / repeat
//   btn_level  out  1  debounced button level
//   pulse_cnt  out  8  count of emitted ce_out strobes, wraps 255 -> 0
//
// The FSM state register state_q (type state_e) is the debug view of the
// debouncer and can be bound to directly.
// -----------------------------------------------------------------------------
module pnu_debounce_pulse #(
  parameter int CNT_W         = 16,
  parameter int DEBOUNCE_CYC  = 50000,
  parameter int REPEAT_DELAY  = 25000,
  parameter int REPEAT_PERIOD = 10000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_in,
  input  logic       en,
  output logic       ce_out,
  output logic       btn_level,
  output logic [7:0] pulse_cnt
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // IDLE: released and stable; ARM: qualifying a press;
  // HELD: pressed and stable; REL: qualifying a release.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    HELD = 2'd2,
    REL  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             s1_q, s2_q;
  logic             ce_q, ce_d;
  logic             level_q, level_d;
  logic [7:0]       pulse_cnt_q, pulse_cnt_d;
  logic             fire;

`ifdef PNU_DEBOUNCE_REPEAT_EN
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);
  // 0: waiting for the first repeat (REPEAT_DELAY); 1: periodic repeats.
  logic phase_q, phase_d;
`else
  logic unused_repeat;
  assign unused_repeat = (REPEAT_DELAY > 0) ^ (REPEAT_PERIOD > 0);
`endif

  // Two-flop synchronizer; the FSM only ever looks at s2_q.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= btn_in;
      s2_q <= s1_q;
    end
  end

  // Next-state logic. The counter is shared by press and release
  // qualification, and by repeat timing when that feature is built in.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fire    = 1'b0;
`ifdef PNU_DEBOUNCE_REPEAT_EN
    phase_d = phase_q;
`endif
    case (state_q)
      IDLE: begin
        if (s2_q) begin
          state_d = ARM;
          cnt_d   = '0;
        end
      end
      ARM: begin
        if (!s2_q) begin
          state_d = IDLE;             // bounce: drop back, no strobe
        end else if (cnt_q == DB_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          fire    = 1'b1;
`ifdef PNU_DEBOUNCE_REPEAT_EN
          phase_d = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HELD: begin
        if (!s2_q) begin
          state_d = REL;
          cnt_d   = '0;
`ifdef PNU_DEBOUNCE_REPEAT_EN
          phase_d = 1'b0;
        end else if (!phase_q && (cnt_q == RD_LAST)) begin
          fire    = 1'b1;
          cnt_d   = '0;
          phase_d = 1'b1;
        end else if (phase_q && (cnt_q == RP_LAST)) begin
          fire  = 1'b1;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
`endif
        end
      end
      REL: begin
        if (s2_q) begin
          state_d = HELD;             // release was a bounce; no strobe
          cnt_d   = '0;
`ifdef PNU_DEBOUNCE_REPEAT_EN
          phase_d = 1'b0;             // repeat timing restarts from DELAY
`endif
        end else if (cnt_q == DB_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // A strobe that lands while en=0 is dropped, not deferred.
    ce_d        = fire & en;
    level_d     = (state_d == HELD) || (state_d == REL);
    pulse_cnt_d = pulse_cnt_q;
    if (ce_d) begin
      pulse_cnt_d = pulse_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ce_q        <= 1'b0;
      level_q     <= 1'b0;
      pulse_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ce_q        <= ce_d;
      level_q     <= level_d;
      pulse_cnt_q <= pulse_cnt_d;
    end
  end

`ifdef PNU_DEBOUNCE_REPEAT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      phase_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
    end
  end
`endif

  assign ce_out    = ce_q;
  assign btn_level = level_q;
  assign pulse_cnt = pulse_cnt_q;

endmodule

// File: tb/tb_pnu_debounce_pulse.sv
// -----------------------------------------------------------------------------
// tb_pnu_debounce_pulse
//   Self-checking bench for pnu_debounce_pulse. The reference model takes the
//   button sample from two edges earlier and counts how many consecutive
//   samples disagree with the debounced level. The level flips after
//   DEBOUNCE_CYC+1 such samples. Auto-repeat (when built in) is modelled from
//   the age of the current stable hold.
// -----------------------------------------------------------------------------
module tb_pnu_debounce_pulse;

  localparam int D  = 4;
  localparam int RD = 6;
  localparam int RP = 3;
`ifdef PNU_DEBOUNCE_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       btn_in = 1'b0;
  logic       en = 1'b1;
  logic       ce_out;
  logic       btn_level;
  logic [7:0] pulse_cnt;

  always #5 clock = ~clock;

  pnu_debounce_pulse #(
    .CNT_W        (16),
    .DEBOUNCE_CYC (D),
    .REPEAT_DELAY (RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .btn_in   (btn_in),
    .en       (en),
    .ce_out   (ce_out),
    .btn_level(btn_level),
    .pulse_cnt(pulse_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- reference model ----------------
  logic [1:0] m_hist  = 2'b00;  // [0] = newest sample, [1] = what the FSM sees
  logic       m_level = 1'b0;
  logic       m_ce    = 1'b0;
  logic [7:0] m_cnt   = 8'd0;
  int         m_run   = 0;      // consecutive samples disagreeing with m_level
  int         m_age   = 0;      // edges since the current stable hold began

  // Advance one clock edge: update the model from the inputs present at the
  // edge, then settle 1 time unit past the edge before anyone samples.
  task automatic step();
    logic x;
    logic fire;
    logic resumed;
    @(posedge clock);
    if (reset) begin
      m_hist  = 2'b00;
      m_level = 1'b0;
      m_ce    = 1'b0;
      m_cnt   = 8'd0;
      m_run   = 0;
      m_age   = 0;
    end else begin
      x    = m_hist[1];
      fire = 1'b0;
      if (x != m_level) begin
        m_run = m_run + 1;
        if (m_run == D + 1) begin
          m_level = x;
          m_run   = 0;
          if (x) begin
            fire  = 1'b1;
            m_age = 0;
          end
        end
      end else begin
        resumed = m_level && (m_run > 0);
        m_run   = 0;
        if (m_level) begin
          if (resumed) begin
            m_age = 0;
          end else begin
            m_age = m_age + 1;
            if (REP && ((m_age == RD) || ((m_age > RD) && ((m_age - RD) % RP == 0))))
              fire = 1'b1;
          end
        end
      end
      m_ce = fire && en;
      if (m_ce) m_cnt = m_cnt + 8'd1;
      m_hist = {m_hist[0], btn_in};
    end
    #1;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    btn_in = 1'b0;
    en     = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset  = 1'b1;
    btn_in = 1'b0;
    en     = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++;
      if (ce_out !== 1'b0 || btn_level !== 1'b0 || pulse_cnt !== 8'd0) begin
        n_bad++;
        $display("FAIL reset: ce=%b lvl=%b cnt=%0d, want 0/0/0", ce_out, btn_level, pulse_cnt);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_press_latency();
    do_reset();
    for (int i = 0; i < 3; i++) step();
    btn_in = 1'b1;          // first sampled high at the next edge (i = 0)
    for (int i = 0; i <= D + 6; i++) begin
      step();
      n_cmp++;
      if (ce_out !== (i == D + 2) || btn_level !== (i >= D + 2) ||
          ce_out !== m_ce || btn_level !== m_level || pulse_cnt !== m_cnt) begin
        n_bad++;
        $display("FAIL press_latency i=%0d: ce=%b lvl=%b cnt=%0d, want ce=%b lvl=%b cnt=%0d",
                 i, ce_out, btn_level, pulse_cnt, m_ce, m_level, m_cnt);
      end
    end
    n_cmp++;
    if (pulse_cnt !== 8'd1) begin
      n_bad++;
      $display("FAIL press_count: cnt=%0d, want 1", pulse_cnt);
    end
    btn_in = 1'b0;          // first low sample at i = 0
    for (int i = 0; i <= D + 4; i++) begin
      step();
      n_cmp++;
      if (btn_level !== (i < D + 2) || ce_out !== 1'b0 || btn_level !== m_level) begin
        n_bad++;
        $display("FAIL release_latency i=%0d: lvl=%b ce=%b, want lvl=%b ce=0",
                 i, btn_level, ce_out, (i < D + 2));
      end
    end
  endtask

  task automatic test_bounce();
    logic [3:0] pat;
    do_reset();
    pat = 4'b0101;          // 1,0,1,0 in time order from bit 0
    for (int i = 0; i < 8; i++) begin
      btn_in = pat[i/2];
      step();
      n_cmp++;
      if (ce_out !== 1'b0 || btn_level !== 1'b0 || pulse_cnt !== m_cnt || m_level !== 1'b0) begin
        n_bad++;
        $display("FAIL bounce i=%0d: ce=%b lvl=%b cnt=%0d, want 0/0/%0d", i, ce_out, btn_level, pulse_cnt, m_cnt);
      end
    end
    btn_in = 1'b0;
    for (int i = 0; i < D + 6; i++) begin
      step();
      n_cmp++;
      if (ce_out !== 1'b0 || btn_level !== 1'b0 || pulse_cnt !== 8'd0) begin
        n_bad++;
        $display("FAIL bounce_tail i=%0d: ce=%b lvl=%b cnt=%0d, want 0/0/0", i, ce_out, btn_level, pulse_cnt);
      end
    end
  endtask

  task automatic test_en_gate();
    logic saw_level;
    do_reset();
    en        = 1'b0;
    btn_in    = 1'b1;
    saw_level = 1'b0;
    for (int i = 0; i < D + 6; i++) begin
      step();
      if (btn_level) saw_level = 1'b1;
      n_cmp++;
      if (ce_out !== m_ce || btn_level !== m_level || pulse_cnt !== m_cnt) begin
        n_bad++;
        $display("FAIL en_gate_off i=%0d: ce=%b lvl=%b cnt=%0d, want %b/%b/%0d",
                 i, ce_out, btn_level, pulse_cnt, m_ce, m_level, m_cnt);
      end
    end
    n_cmp++;
    if (saw_level !== 1'b1 || pulse_cnt !== 8'd0) begin
      n_bad++;
      $display("FAIL en_gate_first: saw_level=%b cnt=%0d, want 1/0", saw_level, pulse_cnt);
    end
    btn_in = 1'b0;
    for (int i = 0; i < D + 6; i++) step();
    en     = 1'b1;
    btn_in = 1'b1;
    for (int i = 0; i < D + 6; i++) begin
      step();
      n_cmp++;
      if (ce_out !== m_ce || btn_level !== m_level || pulse_cnt !== m_cnt) begin
        n_bad++;
        $display("FAIL en_gate_on i=%0d: ce=%b lvl=%b cnt=%0d, want %b/%b/%0d",
                 i, ce_out, btn_level, pulse_cnt, m_ce, m_level, m_cnt);
      end
    end
    n_cmp++;
    if (pulse_cnt !== 8'd1) begin
      n_bad++;
      $display("FAIL en_gate_second: cnt=%0d, want 1", pulse_cnt);
    end
    btn_in = 1'b0;
    for (int i = 0; i < D + 6; i++) step();
  endtask

  task automatic test_reset_mid_held();
    do_reset();
    btn_in = 1'b1;
    for (int i = 0; i < D + 7; i++) step();
    reset = 1'b1;
    step();
    n_cmp++;
    if (ce_out !== 1'b0 || btn_level !== 1'b0 || pulse_cnt !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_mid_held: ce=%b lvl=%b cnt=%0d, want 0/0/0", ce_out, btn_level, pulse_cnt);
    end
    reset = 1'b0;
    for (int i = 0; i <= D + 4; i++) begin
      step();
      n_cmp++;
      if (ce_out !== (i == D + 2) || ce_out !== m_ce || btn_level !== m_level || pulse_cnt !== m_cnt) begin
        n_bad++;
        $display("FAIL requalify i=%0d: ce=%b lvl=%b cnt=%0d, want ce=%b lvl=%b cnt=%0d",
                 i, ce_out, btn_level, pulse_cnt, (i == D + 2), m_level, m_cnt);
      end
    end
    n_cmp++;
    if (pulse_cnt !== 8'd1) begin
      n_bad++;
      $display("FAIL requalify_count: cnt=%0d, want 1", pulse_cnt);
    end
    btn_in = 1'b0;
    for (int i = 0; i < D + 6; i++) step();
  endtask

  task automatic test_wrap();
    int bad_here;
    do_reset();
    bad_here = 0;
    for (int p = 0; p < 256; p++) begin
      for (int i = 0; i < 2 * (D + 4); i++) begin
        btn_in = (i < D + 4);
        step();
        n_cmp++;
        if (ce_out !== m_ce || btn_level !== m_level || pulse_cnt !== m_cnt) begin
          n_bad++;
          bad_here++;
          if (bad_here < 5)
            $display("FAIL wrap p=%0d i=%0d: ce=%b lvl=%b cnt=%0d, want %b/%b/%0d",
                     p, i, ce_out, btn_level, pulse_cnt, m_ce, m_level, m_cnt);
        end
      end
    end
    for (int i = 0; i < D + 4; i++) step();
    n_cmp++;
    if (pulse_cnt !== 8'd0 || btn_level !== 1'b0) begin
      n_bad++;
      $display("FAIL wrap_final: cnt=%0d lvl=%b, want 0/0", pulse_cnt, btn_level);
    end
  endtask

  task automatic test_repeat();
    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];
    int n;
    do_reset();
    exp_q.push_back(16'(D + 2));
    if (REP) begin
      for (int t = RD; t <= 20; t += RP) exp_q.push_back(16'(D + 2 + t));
    end
    btn_in = 1'b1;
    for (int i = 0; i <= D + 2 + 20; i++) begin
      step();
      if (ce_out === 1'b1) got_q.push_back(16'(i));
      n_cmp++;
      if (ce_out !== m_ce || btn_level !== m_level || pulse_cnt !== m_cnt) begin
        n_bad++;
        $display("FAIL repeat_cyc i=%0d: ce=%b lvl=%b cnt=%0d, want %b/%b/%0d",
                 i, ce_out, btn_level, pulse_cnt, m_ce, m_level, m_cnt);
      end
    end
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL repeat_count: got %0d pulses, want %0d", got_q.size(), exp_q.size());
    end
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int k = 0; k < n; k++) begin
      n_cmp++;
      if (got_q[k] !== exp_q[k]) begin
        n_bad++;
        $display("FAIL repeat_time k=%0d: pulse at %0d, want %0d", k, got_q[k], exp_q[k]);
      end
    end
    btn_in = 1'b0;
    for (int i = 0; i < D + 6; i++) step();
  endtask

  task automatic test_random();
    int bad_here;
    int run_left;
    do_reset();
    bad_here = 0;
    run_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (run_left == 0) begin
        btn_in   = ~btn_in;
        run_left = $urandom_range(1, 3 * D + 8);
      end
      run_left = run_left - 1;
      en    = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 299) == 0);
      step();
      n_cmp++;
      if (ce_out !== m_ce || btn_level !== m_level || pulse_cnt !== m_cnt) begin
        n_bad++;
        bad_here++;
        if (bad_here < 5)
          $display("FAIL random i=%0d: ce=%b lvl=%b cnt=%0d, want %b/%b/%0d",
                   i, ce_out, btn_level, pulse_cnt, m_ce, m_level, m_cnt);
      end
    end
    reset = 1'b0;
    en    = 1'b1;
  endtask

  initial begin
    test_reset();
    test_press_latency();
    test_bounce();
    test_en_gate();
    test_reset_mid_held();
    test_repeat();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
